// File: rtl/ahblite_busmatrix_pkg.sv
// Shared types for the AHB-lite bus matrix output stages.
// Transfer/owner encodings and the address-phase bundle.
package ahblite_busmatrix_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_ICODE = 2'b01,
    OWN_DCODE = 2'b10
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } ahb_aphase_t;

  localparam ahb_aphase_t APHASE_IDLE = '0;

  function automatic logic is_req(
    input logic       sel,
    input logic [1:0] trans
  );
    return sel & trans[1];
  endfunction

  // Owner keeps the slave mid-burst or while locked.
  function automatic logic holds(
    input logic [1:0] trans,
    input logic       lock
  );
    return lock |
           (trans == HT_SEQ) |
           (trans == HT_BUSY);
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_arb_core.sv
// Next-owner priority logic with ICODE starvation guard.
// Shared by the ROM, RAM and peripheral output stages.
import ahblite_busmatrix_pkg::*;

module ahblite_busmatrix_arb_core #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       arb_en,
  input  logic       req_icode,
  input  logic       req_dcode,
  input  owner_e     owner,
  input  logic [1:0] trans_icode,
  input  logic [1:0] trans_dcode,
  input  logic       lock_icode,
  input  logic       lock_dcode,
  output owner_e     next_owner
);

  localparam logic [3:0] LIMIT =
    4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       hold;
  logic       starved;

  always_comb begin
    hold = 1'b0;
    unique case (owner)
      OWN_ICODE:
        hold = holds(trans_icode, lock_icode);
      OWN_DCODE:
        hold = holds(trans_dcode, lock_dcode);
      default:
        hold = 1'b0;
    endcase
  end

  assign starved =
    (starve_cnt == LIMIT) & req_icode;

  always_comb begin
    next_owner = OWN_NONE;
    priority case (1'b1)
      hold:      next_owner = owner;
      starved:   next_owner = OWN_ICODE;
      req_dcode: next_owner = OWN_DCODE;
      req_icode: next_owner = OWN_ICODE;
      default:   next_owner = OWN_NONE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (next_owner == OWN_ICODE ||
          !req_icode) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ahblite_busmatrix_outputstage_rom.sv
// ROM output stage: arbitrates ICODE/DCODE, muxes the
// address phase and tracks data-phase ownership.
import ahblite_busmatrix_pkg::*;

module ahblite_busmatrix_outputstage_rom #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL_Decoder_ICODE_ROM,
  input  logic [31:0] HADDR_ICODE,
  input  logic [1:0]  HTRANS_ICODE,
  input  logic        HWRITE_ICODE,
  input  logic [2:0]  HSIZE_ICODE,
  input  logic [2:0]  HBURST_ICODE,
  input  logic [3:0]  HPROT_ICODE,
  input  logic        HMASTLOCK_ICODE,
  input  logic        HSEL_Decoder_DCODE_ROM,
  input  logic [31:0] HADDR_DCODE,
  input  logic [1:0]  HTRANS_DCODE,
  input  logic        HWRITE_DCODE,
  input  logic [2:0]  HSIZE_DCODE,
  input  logic [2:0]  HBURST_DCODE,
  input  logic [3:0]  HPROT_DCODE,
  input  logic        HMASTLOCK_DCODE,
  input  logic        HREADYOUT_ROM,
  output logic        ACTIVE_Outputstage_ROM_ICODE,
  output logic        ACTIVE_Outputstage_ROM_DCODE,
  output logic        HREADYOUT_Outputstage_ROM_ICODE,
  output logic        HREADYOUT_Outputstage_ROM_DCODE,
  output logic        HSEL_ROM,
  output logic [31:0] HADDR_ROM,
  output logic [1:0]  HTRANS_ROM,
  output logic        HWRITE_ROM,
  output logic [2:0]  HSIZE_ROM,
  output logic [2:0]  HBURST_ROM,
  output logic [3:0]  HPROT_ROM,
  output logic        HMASTLOCK_ROM,
  output logic        HREADY_ROM
);

  owner_e      addr_owner;
  owner_e      data_owner;
  owner_e      next_owner;
  ahb_aphase_t ap_icode;
  ahb_aphase_t ap_dcode;
  ahb_aphase_t ap_rom;
  logic        req_icode;
  logic        req_dcode;

  assign ap_icode = '{
    addr:  HADDR_ICODE,
    trans: HTRANS_ICODE,
    write: HWRITE_ICODE,
    size:  HSIZE_ICODE,
    burst: HBURST_ICODE,
    prot:  HPROT_ICODE,
    lock:  HMASTLOCK_ICODE
  };

  assign ap_dcode = '{
    addr:  HADDR_DCODE,
    trans: HTRANS_DCODE,
    write: HWRITE_DCODE,
    size:  HSIZE_DCODE,
    burst: HBURST_DCODE,
    prot:  HPROT_DCODE,
    lock:  HMASTLOCK_DCODE
  };

  assign req_icode = is_req(
    HSEL_Decoder_ICODE_ROM, HTRANS_ICODE);
  assign req_dcode = is_req(
    HSEL_Decoder_DCODE_ROM, HTRANS_DCODE);

  ahblite_busmatrix_arb_core #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .arb_en      (HREADYOUT_ROM),
    .req_icode   (req_icode),
    .req_dcode   (req_dcode),
    .owner       (addr_owner),
    .trans_icode (HTRANS_ICODE),
    .trans_dcode (HTRANS_DCODE),
    .lock_icode  (HMASTLOCK_ICODE),
    .lock_dcode  (HMASTLOCK_DCODE),
    .next_owner  (next_owner)
  );

  // Ownership only moves when the slave accepts a beat.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_owner <= OWN_NONE;
      data_owner <= OWN_NONE;
    end else if (HREADYOUT_ROM) begin
      addr_owner <= next_owner;
      data_owner <= ap_rom.trans[1] ?
                    addr_owner : OWN_NONE;
    end
  end

  always_comb begin
    ap_rom = APHASE_IDLE;
    unique case (addr_owner)
      OWN_ICODE: ap_rom = ap_icode;
      OWN_DCODE: ap_rom = ap_dcode;
      default:   ap_rom = APHASE_IDLE;
    endcase
  end

  assign HSEL_ROM      = (addr_owner != OWN_NONE);
  assign HADDR_ROM     = ap_rom.addr;
  assign HTRANS_ROM    = ap_rom.trans;
  assign HWRITE_ROM    = ap_rom.write;
  assign HSIZE_ROM     = ap_rom.size;
  assign HBURST_ROM    = ap_rom.burst;
  assign HPROT_ROM     = ap_rom.prot;
  assign HMASTLOCK_ROM = ap_rom.lock;
  assign HREADY_ROM    = HREADYOUT_ROM;

  assign ACTIVE_Outputstage_ROM_ICODE =
    (addr_owner == OWN_ICODE);
  assign ACTIVE_Outputstage_ROM_DCODE =
    (addr_owner == OWN_DCODE);

  assign HREADYOUT_Outputstage_ROM_ICODE =
    (data_owner == OWN_ICODE) ?
    HREADYOUT_ROM : 1'b1;
  assign HREADYOUT_Outputstage_ROM_DCODE =
    (data_owner == OWN_DCODE) ?
    HREADYOUT_ROM : 1'b1;

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage_rom.sv
// Scoreboard bench for the ROM output stage: directed
// scenarios plus random traffic against a reference model.
module tb_ahblite_busmatrix_outputstage_rom;

  localparam int LIM = 4;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sel_i, sel_d;
  logic [31:0] addr_i, addr_d;
  logic [1:0]  tr_i, tr_d;
  logic        wr_i, wr_d;
  logic [2:0]  sz_i, sz_d, bu_i, bu_d;
  logic [3:0]  pr_i, pr_d;
  logic        lk_i, lk_d;
  logic        rdy;
  logic        act_i, act_d, ro_i, ro_d;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hlock, hready;

  always #5 HCLK = ~HCLK;

  ahblite_busmatrix_outputstage_rom #(
    .STARVE_LIMIT (LIM)
  ) dut (
    .HCLK                            (HCLK),
    .HRESETn                         (HRESETn),
    .HSEL_Decoder_ICODE_ROM          (sel_i),
    .HADDR_ICODE                     (addr_i),
    .HTRANS_ICODE                    (tr_i),
    .HWRITE_ICODE                    (wr_i),
    .HSIZE_ICODE                     (sz_i),
    .HBURST_ICODE                    (bu_i),
    .HPROT_ICODE                     (pr_i),
    .HMASTLOCK_ICODE                 (lk_i),
    .HSEL_Decoder_DCODE_ROM          (sel_d),
    .HADDR_DCODE                     (addr_d),
    .HTRANS_DCODE                    (tr_d),
    .HWRITE_DCODE                    (wr_d),
    .HSIZE_DCODE                     (sz_d),
    .HBURST_DCODE                    (bu_d),
    .HPROT_DCODE                     (pr_d),
    .HMASTLOCK_DCODE                 (lk_d),
    .HREADYOUT_ROM                   (rdy),
    .ACTIVE_Outputstage_ROM_ICODE    (act_i),
    .ACTIVE_Outputstage_ROM_DCODE    (act_d),
    .HREADYOUT_Outputstage_ROM_ICODE (ro_i),
    .HREADYOUT_Outputstage_ROM_DCODE (ro_d),
    .HSEL_ROM                        (hsel),
    .HADDR_ROM                       (haddr),
    .HTRANS_ROM                      (htrans),
    .HWRITE_ROM                      (hwrite),
    .HSIZE_ROM                       (hsize),
    .HBURST_ROM                      (hburst),
    .HPROT_ROM                       (hprot),
    .HMASTLOCK_ROM                   (hlock),
    .HREADY_ROM                      (hready)
  );

  typedef struct packed {
    logic        act_i, act_d, ro_i, ro_d, hsel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size, burst;
    logic [3:0]  prot;
    logic        lock, hready;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_no = 0;

  // Model state: 0 none, 1 ICODE, 2 DCODE.
  int   m_aown, m_down, m_cnt;
  bit   m_valid = 0;

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.act_i  = (m_aown == 1);
    e.act_d  = (m_aown == 2);
    e.ro_i   = (m_down == 1) ? rdy : 1'b1;
    e.ro_d   = (m_down == 2) ? rdy : 1'b1;
    e.hready = rdy;
    if (m_aown == 1) begin
      e.hsel = 1'b1; e.addr = addr_i;
      e.trans = tr_i; e.write = wr_i;
      e.size = sz_i; e.burst = bu_i;
      e.prot = pr_i; e.lock = lk_i;
    end else if (m_aown == 2) begin
      e.hsel = 1'b1; e.addr = addr_d;
      e.trans = tr_d; e.write = wr_d;
      e.size = sz_d; e.burst = bu_d;
      e.prot = pr_d; e.lock = lk_d;
    end
    return e;
  endfunction

  task automatic model_update();
    bit ri, rd, hold;
    logic [1:0] otr;
    int nxt;
    if (!HRESETn) begin
      m_aown = 0; m_down = 0; m_cnt = 0;
      m_valid = 1;
      return;
    end
    if (!rdy) return;
    ri = sel_i && tr_i[1];
    rd = sel_d && tr_d[1];
    otr = (m_aown == 1) ? tr_i :
          (m_aown == 2) ? tr_d : ID;
    hold = (m_aown == 1 && (tr_i == SQ || tr_i == BZ || lk_i)) ||
           (m_aown == 2 && (tr_d == SQ || tr_d == BZ || lk_d));
    if (hold) nxt = m_aown;
    else if (m_cnt == LIM && ri) nxt = 1;
    else if (rd) nxt = 2;
    else if (ri) nxt = 1;
    else nxt = 0;
    m_down = otr[1] ? m_aown : 0;
    if (nxt == 1 || !ri) m_cnt = 0;
    else if (m_cnt < LIM) m_cnt = m_cnt + 1;
    m_aown = nxt;
  endtask

  task automatic cyc(
    input logic rn,
    input logic si, input logic [1:0] ti, input logic li,
    input logic sd, input logic [1:0] td, input logic ld,
    input logic r,
    input logic [31:0] ai, input logic [31:0] ad
  );
    @(posedge HCLK);
    model_update();
    #1;
    HRESETn = rn; rdy = r;
    sel_i = si; tr_i = ti; lk_i = li; addr_i = ai;
    sel_d = sd; tr_d = td; lk_d = ld; addr_d = ad;
    wr_i = 1'($urandom); wr_d = 1'($urandom);
    sz_i = 3'($urandom); sz_d = 3'($urandom);
    bu_i = 3'($urandom); bu_d = 3'($urandom);
    pr_i = 4'($urandom); pr_d = 4'($urandom);
    cyc_no++;
    if (m_valid) exp_q.push_back(model_out());
  endtask

  // Monitor: compare the DUT outputs against queued expectations.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{act_i, act_d, ro_i, ro_d, hsel,
              haddr, htrans, hwrite, hsize,
              hburst, hprot, hlock, hready};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @cyc%0d: got %h exp %h",
                   cyc_no, a, e);
        end
      end
    end
  end

  initial begin
    HRESETn = 0; rdy = 1;
    sel_i = 1; tr_i = NS; lk_i = 0; addr_i = 0;
    sel_d = 1; tr_d = NS; lk_d = 0; addr_d = 0;
    wr_i = 0; wr_d = 0; sz_i = 0; sz_d = 0;
    bu_i = 0; bu_d = 0; pr_i = 0; pr_d = 0;
    // Reset held with both requesting.
    cyc(0, 1, NS, 0, 1, NS, 0, 1, 32'h10, 32'h20);
    cyc(0, 1, NS, 0, 1, NS, 0, 1, 32'h10, 32'h20);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    // Single ICODE access.
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h40, 0);
    cyc(1, 1, ID, 0, 0, ID, 0, 1, 32'h40, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 0, 32'h40, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 32'h40, 0);
    // Simultaneous requests, then DCODE idles.
    cyc(1, 1, NS, 0, 1, NS, 0, 1, 32'h100, 32'h200);
    cyc(1, 1, NS, 0, 1, NS, 0, 1, 32'h100, 32'h200);
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h100, 32'h200);
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h100, 32'h200);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    // DCODE INCR4 with two wait states, ICODE pending.
    cyc(1, 1, NS, 0, 1, NS, 0, 1, 32'h300, 32'h400);
    cyc(1, 1, NS, 0, 1, NS, 0, 1, 32'h300, 32'h400);
    cyc(1, 1, NS, 0, 1, SQ, 0, 1, 32'h300, 32'h404);
    cyc(1, 1, NS, 0, 1, SQ, 0, 0, 32'h300, 32'h408);
    cyc(1, 1, NS, 0, 1, SQ, 0, 0, 32'h300, 32'h408);
    cyc(1, 1, NS, 0, 1, SQ, 0, 1, 32'h300, 32'h408);
    cyc(1, 1, NS, 0, 1, SQ, 0, 1, 32'h300, 32'h40C);
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h300, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    // Starvation: DCODE streams singles.
    for (int k = 0; k < 10; k++)
      cyc(1, 1, NS, 0, 1, NS, 0, 1,
          32'h500, 32'h600 + 32'(k * 4));
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    // Reset during a waited data phase.
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h700, 0);
    cyc(1, 1, ID, 0, 0, ID, 0, 1, 32'h700, 0);
    cyc(0, 0, ID, 0, 0, ID, 0, 0, 32'h700, 0);
    cyc(1, 1, NS, 0, 0, ID, 0, 1, 32'h704, 0);
    cyc(1, 1, ID, 0, 0, ID, 0, 1, 32'h704, 0);
    cyc(1, 0, ID, 0, 0, ID, 0, 1, 0, 0);
    // Random traffic.
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(99) != 0,
          $urandom_range(9) < 8, 2'($urandom),
          $urandom_range(9) == 0,
          $urandom_range(9) < 8, 2'($urandom),
          $urandom_range(9) == 0,
          $urandom_range(3) != 0,
          $urandom, $urandom);
    repeat (3) @(negedge HCLK);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending exp 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahblite_busmatrix_outputstage_rom.md
# ahblite_busmatrix_outputstage_rom

Output stage of the AHB-lite bus matrix in front of the ROM slave. It arbitrates between the ICODE and DCODE decoders, forwards the winner's address phase to the ROM, and tracks data-phase ownership. It returns the per-decoder ACTIVE and HREADYOUT signals that the decoders consume. DCODE has priority, bursts and locked sequences are never broken, and a starvation counter guarantees ICODE progress.

## Interface
- STARVE_LIMIT, 4: lost arbitrations after which a pending ICODE request wins once (1..15).
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low
- HSEL_Decoder_ICODE_ROM / HSEL_Decoder_DCODE_ROM  in  1  decoder select for ROM
- HADDR_ICODE / HADDR_DCODE  in  32  address
- HTRANS_ICODE / HTRANS_DCODE  in  2  transfer type
- HWRITE_x, HSIZE_x[2:0], HBURST_x[2:0], HPROT_x[3:0], HMASTLOCK_x  in  control per decoder (x = ICODE, DCODE)
- HREADYOUT_ROM  in  1  slave ready
- ACTIVE_Outputstage_ROM_ICODE / _DCODE  out  1  decoder currently owns the ROM address phase
- HREADYOUT_Outputstage_ROM_ICODE / _DCODE  out  1  ready returned to each decoder
- HSEL_ROM, HADDR_ROM[31:0], HTRANS_ROM[1:0], HWRITE_ROM, HSIZE_ROM[2:0], HBURST_ROM[2:0], HPROT_ROM[3:0], HMASTLOCK_ROM, HREADY_ROM  out  muxed slave address phase

## Operation
- Request: req_x = HSEL_Decoder_x_ROM & HTRANS_x[1] (NONSEQ or SEQ).
- Registers:
  - addr_owner ∈ {NONE, ICODE, DCODE}
  - data_owner ∈ {NONE, ICODE, DCODE}
  - starve_cnt, 4-bit saturating at STARVE_LIMIT
- Arbitration point: any rising edge with HREADYOUT_ROM=1. addr_owner is never updated when HREADYOUT_ROM=0.
- Next owner, first matching rule wins:
  1. Hold: current owner has HTRANS = SEQ or BUSY, or HMASTLOCK=1 → keep the owner.
  2. Starvation: starve_cnt == STARVE_LIMIT and req_ICODE → ICODE.
  3. req_DCODE → DCODE.
  4. req_ICODE → ICODE.
  5. Otherwise → NONE.
- starve_cnt update at each arbitration point:
  - Clear when ICODE is granted or req_ICODE = 0.
  - Increment (saturating) when req_ICODE = 1 and DCODE is chosen.
- Address mux: driven from the registered addr_owner.
  - HSEL_ROM = (addr_owner != NONE).
  - With owner NONE, all address and control outputs are 0 and HTRANS_ROM = IDLE.
  - HREADY_ROM = HREADYOUT_ROM.
- Data phase: at each arbitration point, data_owner ← addr_owner if HTRANS_ROM[1], else NONE.
- ACTIVE_Outputstage_ROM_x = (addr_owner == x). A decoder seeing ACTIVE=0 holds its transfer in its input stage.
- HREADYOUT_Outputstage_ROM_x = HREADYOUT_ROM if data_owner == x, else 1. HRESP and HRDATA go from the slave straight to the decoders and do not pass through this block.

## Timing
- Reset: HRESETn sampled low at an edge sets addr_owner = NONE, data_owner = NONE, starve_cnt = 0. All outputs are then 0, except both HREADYOUT_Outputstage outputs = 1 and HREADY_ROM = HREADYOUT_ROM.
- Reset mid-transfer: the in-flight transfer is dropped and no state is retained.
- Grant latency: 1 cycle. A request first asserted in cycle N, with ROM idle and ready, gives ACTIVE=1 and drives the address onto the ROM in cycle N+1.
- Back-to-back: the owner keeps ACTIVE across consecutive NONSEQ transfers only while it wins rule 3 or 4. Ownership changes only at arbitration points.
- Simultaneous first requests: DCODE wins and ICODE sees ACTIVE=0.
- Wait states: with HREADYOUT_ROM=0, addr_owner, data_owner and starve_cnt are all frozen.
- BUSY inside a burst keeps the owner. IDLE from the owner releases it at the next arbitration point.

## Structure
- Shared package ahblite_busmatrix_pkg holds:
  - HTRANS encodings: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - Owner encoding: NONE=2'b00, ICODE=2'b01, DCODE=2'b10.
- Sub-module ahblite_busmatrix_arb_core: the combinational next-owner priority logic plus the starve_cnt register. It is reused by future RAM and peripheral output stages. The mux and ownership registers stay in the top module.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles while both requests are asserted → ACTIVE both 0, HSEL_ROM=0, HTRANS_ROM=00, HREADYOUT_Outputstage both 1.
- Single ICODE NONSEQ to 0x0000_0040, ROM ready → next cycle ACTIVE_ICODE=1 and HADDR_ROM=0x40. One cycle later HREADYOUT_Outputstage_ROM_ICODE follows HREADYOUT_ROM.
- Simultaneous ICODE and DCODE NONSEQ → DCODE owns. ICODE gains ownership at the first arbitration point after DCODE goes IDLE.
- DCODE INCR4 burst (NONSEQ, SEQ×3) with ICODE requesting throughout, plus 2 ROM wait states on beat 2 → no owner change until after beat 4. Ownership frozen during the wait states.
- STARVE_LIMIT=4: DCODE issues continuous single NONSEQ transfers while ICODE requests → ICODE granted at the 5th arbitration point and starve_cnt returns to 0.
- HRESETn low during a data phase with ROM wait state → the next cycle has both owners NONE. A fresh ICODE request is granted 1 cycle after reset release.
